// File: rtl/fb_pkg.sv
// Shared widths and types for the framebuffer memory arbiter.
package fb_pkg;

    localparam int FB_ADDR_W = 23;
    localparam int FB_DATA_W = 8;

    typedef enum logic {
        OWN_DISP = 1'b0,
        OWN_SIM  = 1'b1
    } fb_owner_t;

    typedef struct packed {
        logic      valid;
        fb_owner_t owner;
    } fb_tag_t;

    localparam fb_tag_t FB_TAG_NONE = '{valid: 1'b0, owner: OWN_DISP};

endpackage

// File: rtl/fb_rd_tag_pipe.sv
// Shift register tracking which master owns each in-flight read.
module fb_rd_tag_pipe
    import fb_pkg::*;
#(
    parameter int RD_LAT = 2
) (
    input  logic    clk,
    input  logic    i_clr,
    input  fb_tag_t i_tag,
    output fb_tag_t o_tag
);

    fb_tag_t r_stage [RD_LAT];

    // Advance tags one stage per cycle; clearing drops every in-flight read.
    always_ff @(posedge clk) begin
        if (i_clr) begin
            for (int i = 0; i < RD_LAT; i++) begin
                r_stage[i] <= FB_TAG_NONE;
            end
        end else begin
            r_stage[0] <= i_tag;
            for (int i = 1; i < RD_LAT; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_tag = r_stage[RD_LAT-1];

endmodule

// File: rtl/fb_mem_arbiter.sv
// Arbitrates the framebuffer port between the display fetcher and the sim engine,
// with a one-entry command register and tagged read-data return.
module fb_mem_arbiter
    import fb_pkg::*;
#(
    parameter int RD_LAT         = 2,
    parameter int MAX_DISP_BURST = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 disp_req,
    input  logic                 disp_urgent,
    input  logic [FB_ADDR_W-1:0] disp_addr,
    output logic                 disp_gnt,
    output logic                 disp_rvalid,
    output logic [FB_DATA_W-1:0] disp_rdata,
    input  logic                 sim_req,
    input  logic                 sim_we,
    input  logic [FB_ADDR_W-1:0] sim_addr,
    input  logic [FB_DATA_W-1:0] sim_wdata,
    output logic                 sim_gnt,
    output logic                 sim_rvalid,
    output logic [FB_DATA_W-1:0] sim_rdata,
    output logic [FB_ADDR_W-1:0] address,
    output logic                 read,
    output logic                 write,
    output logic [FB_DATA_W-1:0] writedata,
    input  logic                 waitrequest,
    input  logic [FB_DATA_W-1:0] readdata
);

    localparam int BW = $clog2(MAX_DISP_BURST + 1);

    logic            r_cmd_valid;
    fb_owner_t       r_owner;
    logic [BW-1:0]   r_burst_cnt;
    logic            w_accept;
    logic            w_load;
    logic            w_burst_ok;
    logic            w_sel_disp;
    logic            w_sel_sim;
    fb_tag_t         w_tag_in;
    fb_tag_t         w_tag_out;

    assign w_accept   = r_cmd_valid & ~waitrequest;
    assign w_load     = ~r_cmd_valid | w_accept;
    assign w_burst_ok = (r_burst_cnt < BW'(MAX_DISP_BURST));
    // Urgent display or an idle sim side bypasses the burst limit.
    assign w_sel_disp = ~reset & w_load & disp_req & (disp_urgent | ~sim_req | w_burst_ok);
    assign w_sel_sim  = ~reset & w_load & ~w_sel_disp & sim_req;
    assign disp_gnt   = w_sel_disp;
    assign sim_gnt    = w_sel_sim;

    // Command register: loads a new command whenever the previous one is gone or accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cmd_valid <= 1'b0;
            r_owner     <= OWN_DISP;
            address     <= '0;
            read        <= 1'b0;
            write       <= 1'b0;
            writedata   <= '0;
        end else if (w_load) begin
            if (w_sel_disp) begin
                r_cmd_valid <= 1'b1;
                r_owner     <= OWN_DISP;
                address     <= disp_addr;
                read        <= 1'b1;
                write       <= 1'b0;
                writedata   <= '0;
            end else if (w_sel_sim) begin
                r_cmd_valid <= 1'b1;
                r_owner     <= OWN_SIM;
                address     <= sim_addr;
                read        <= ~sim_we;
                write       <= sim_we;
                writedata   <= sim_wdata;
            end else begin
                r_cmd_valid <= 1'b0;
                read        <= 1'b0;
                write       <= 1'b0;
            end
        end
    end

    // Count display grants that make a waiting sim request wait; saturates at the limit.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_burst_cnt <= '0;
        end else if (~sim_req | w_sel_sim) begin
            r_burst_cnt <= '0;
        end else if (w_sel_disp & w_burst_ok) begin
            r_burst_cnt <= r_burst_cnt + BW'(1);
        end
    end

    always_comb begin
        w_tag_in       = FB_TAG_NONE;
        w_tag_in.valid = w_accept & read;
        w_tag_in.owner = r_owner;
    end

    fb_rd_tag_pipe #(.RD_LAT(RD_LAT)) u_tag_pipe (
        .clk   (clk),
        .i_clr (reset),
        .i_tag (w_tag_in),
        .o_tag (w_tag_out)
    );

    // Register returning read data toward the owner named by the tag.
    always_ff @(posedge clk) begin
        if (reset) begin
            disp_rvalid <= 1'b0;
            sim_rvalid  <= 1'b0;
            disp_rdata  <= '0;
            sim_rdata   <= '0;
        end else begin
            disp_rvalid <= w_tag_out.valid & (w_tag_out.owner == OWN_DISP);
            sim_rvalid  <= w_tag_out.valid & (w_tag_out.owner == OWN_SIM);
            if (w_tag_out.valid & (w_tag_out.owner == OWN_DISP)) begin
                disp_rdata <= readdata;
            end
            if (w_tag_out.valid & (w_tag_out.owner == OWN_SIM)) begin
                sim_rdata <= readdata;
            end
        end
    end

endmodule

// File: tb/tb_fb_mem_arbiter.sv
// Self-checking bench for fb_mem_arbiter with a latency memory model and read-return scoreboard.
module tb_fb_mem_arbiter;
    import fb_pkg::*;

    localparam int RD_LAT = 2;
    localparam int MAXB   = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        disp_req, disp_urgent, disp_gnt, disp_rvalid;
    logic [22:0] disp_addr;
    logic [7:0]  disp_rdata;
    logic        sim_req, sim_we, sim_gnt, sim_rvalid;
    logic [22:0] sim_addr;
    logic [7:0]  sim_wdata, sim_rdata;
    logic [22:0] address;
    logic        read, write, waitrequest;
    logic [7:0]  writedata, readdata;

    always #10 clk = ~clk;

    fb_mem_arbiter #(.RD_LAT(RD_LAT), .MAX_DISP_BURST(MAXB)) dut (
        .clk(clk), .reset(reset),
        .disp_req(disp_req), .disp_urgent(disp_urgent), .disp_addr(disp_addr),
        .disp_gnt(disp_gnt), .disp_rvalid(disp_rvalid), .disp_rdata(disp_rdata),
        .sim_req(sim_req), .sim_we(sim_we), .sim_addr(sim_addr), .sim_wdata(sim_wdata),
        .sim_gnt(sim_gnt), .sim_rvalid(sim_rvalid), .sim_rdata(sim_rdata),
        .address(address), .read(read), .write(write), .writedata(writedata),
        .waitrequest(waitrequest), .readdata(readdata)
    );

    int cyc = 0;
    int n_vec = 0;
    int n_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int due; logic own; logic [7:0] data; } exp_t;
    typedef struct { int due; logic [7:0] data; } mem_t;
    exp_t sb[$];
    mem_t mq[$];

    function automatic logic [7:0] mem_f(logic [22:0] a);
        return a[7:0] ^ a[15:8] ^ {1'b0, a[22:16]};
    endfunction

    task automatic chk_val(string tag, logic [31:0] got, logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push_rd(int due, logic own, logic [22:0] a);
        sb.push_back('{due, own, mem_f(a)});
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(string tag);
        chk_val({tag, "_address"}, 32'(address), 32'd0);
        chk_val({tag, "_read"}, 32'(read), 32'd0);
        chk_val({tag, "_write"}, 32'(write), 32'd0);
        chk_val({tag, "_wdata"}, 32'(writedata), 32'd0);
        chk_val({tag, "_dgnt"}, 32'(disp_gnt), 32'd0);
        chk_val({tag, "_sgnt"}, 32'(sim_gnt), 32'd0);
        chk_val({tag, "_drv"}, 32'(disp_rvalid), 32'd0);
        chk_val({tag, "_srv"}, 32'(sim_rvalid), 32'd0);
        chk_val({tag, "_drd"}, 32'(disp_rdata), 32'd0);
        chk_val({tag, "_srd"}, 32'(sim_rdata), 32'd0);
    endtask

    // Memory model: fixed read latency, junk on the bus when no read is due.
    always @(negedge clk) begin
        if (mq.size() > 0 && mq[0].due == cyc) begin
            readdata <= mq[0].data;
            void'(mq.pop_front());
        end else begin
            readdata <= 8'($urandom);
        end
        if (read && !waitrequest) mq.push_back('{cyc + RD_LAT, mem_f(address)});
    end

    // Scoreboard: every cycle, rvalids must match exactly the reads due now.
    always @(negedge clk) begin
        logic       ed, es;
        logic [7:0] d;
        if (cyc > 0) begin
            ed = 1'b0; es = 1'b0; d = 8'd0;
            if (sb.size() > 0 && sb[0].due == cyc) begin
                ed = ~sb[0].own;
                es = sb[0].own;
                d  = sb[0].data;
                void'(sb.pop_front());
            end
            chk_val("disp_rvalid", 32'(disp_rvalid), 32'(ed));
            chk_val("sim_rvalid", 32'(sim_rvalid), 32'(es));
            if (ed) chk_val("disp_rdata", 32'(disp_rdata), 32'(d));
            if (es) chk_val("sim_rdata", 32'(sim_rdata), 32'(d));
        end
    end

    initial begin
        reset = 1'b1; disp_req = 1'b0; disp_urgent = 1'b0; disp_addr = 23'd0;
        sim_req = 1'b0; sim_we = 1'b0; sim_addr = 23'd0; sim_wdata = 8'd0;
        waitrequest = 1'b0;
        repeat (3) step();
        @(negedge clk) chk_zero("rst");
        step();
        reset = 1'b0;
        step();

        // Single display read from idle
        disp_req = 1'b1; disp_addr = 23'h000100;
        @(negedge clk);
        chk_val("t1_dgnt", 32'(disp_gnt), 32'd1);
        chk_val("t1_read_c0", 32'(read), 32'd0);
        push_rd(cyc + 4, 1'b0, disp_addr);
        step();
        disp_req = 1'b0;
        @(negedge clk);
        chk_val("t1_read_c1", 32'(read), 32'd1);
        chk_val("t1_addr", 32'(address), 32'h000100);
        chk_val("t1_write", 32'(write), 32'd0);
        step();
        @(negedge clk) chk_val("t1_idle", 32'(read), 32'd0);
        repeat (4) step();

        // Fairness with both held, then urgent override and saturation
        disp_req = 1'b1; sim_req = 1'b1; sim_we = 1'b1;
        disp_addr = 23'h001000; sim_addr = 23'h002000; sim_wdata = 8'h5A;
        for (int i = 0; i < 10; i++) begin
            logic es;
            es = (i % 5 == 4);
            @(negedge clk);
            chk_val("t2_dgnt", 32'(disp_gnt), 32'(!es));
            chk_val("t2_sgnt", 32'(sim_gnt), 32'(es));
            if (!es) push_rd(cyc + 4, 1'b0, disp_addr);
            step();
            if (!es) disp_addr = disp_addr + 23'd1;
            else sim_addr = sim_addr + 23'd1;
        end
        disp_urgent = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk_val("t2u_dgnt", 32'(disp_gnt), 32'd1);
            chk_val("t2u_sgnt", 32'(sim_gnt), 32'd0);
            push_rd(cyc + 4, 1'b0, disp_addr);
            step();
            disp_addr = disp_addr + 23'd1;
        end
        disp_urgent = 1'b0;
        @(negedge clk);
        chk_val("t2_sat_sgnt", 32'(sim_gnt), 32'd1);
        chk_val("t2_sat_dgnt", 32'(disp_gnt), 32'd0);
        step();
        disp_req = 1'b0; sim_req = 1'b0;
        repeat (5) step();

        // Stalled sim write at top address, display waiting behind it
        sim_req = 1'b1; sim_we = 1'b1; sim_addr = 23'h7FFFFF; sim_wdata = 8'hA5;
        waitrequest = 1'b1;
        @(negedge clk) chk_val("t3_sgnt", 32'(sim_gnt), 32'd1);
        step();
        sim_req = 1'b0; disp_req = 1'b1; disp_addr = 23'h0ABCDE;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) waitrequest = 1'b0;
            @(negedge clk);
            chk_val("t3_write", 32'(write), 32'd1);
            chk_val("t3_read", 32'(read), 32'd0);
            chk_val("t3_addr", 32'(address), 32'h7FFFFF);
            chk_val("t3_wdata", 32'(writedata), 32'hA5);
            chk_val("t3_sgnt_once", 32'(sim_gnt), 32'd0);
            chk_val("t3_dgnt", 32'(disp_gnt), 32'(i == 3));
            if (i == 3) push_rd(cyc + 4, 1'b0, disp_addr);
            step();
        end
        disp_req = 1'b0;
        @(negedge clk);
        chk_val("t3_next_read", 32'(read), 32'd1);
        chk_val("t3_next_addr", 32'(address), 32'h0ABCDE);
        repeat (5) step();

        // Interleaved D, S, D reads back-to-back
        disp_req = 1'b1; disp_addr = 23'h000011;
        @(negedge clk) chk_val("t4_dgnt0", 32'(disp_gnt), 32'd1);
        push_rd(cyc + 4, 1'b0, disp_addr);
        step();
        disp_req = 1'b0; sim_req = 1'b1; sim_we = 1'b0; sim_addr = 23'h000022;
        @(negedge clk) chk_val("t4_sgnt", 32'(sim_gnt), 32'd1);
        push_rd(cyc + 4, 1'b1, sim_addr);
        step();
        sim_req = 1'b0; disp_req = 1'b1; disp_addr = 23'h000033;
        @(negedge clk);
        chk_val("t4_dgnt1", 32'(disp_gnt), 32'd1);
        chk_val("t4_sim_read", 32'(read), 32'd1);
        chk_val("t4_sim_addr", 32'(address), 32'h000022);
        push_rd(cyc + 4, 1'b0, disp_addr);
        step();
        disp_req = 1'b0;
        repeat (6) step();

        // Reset with two reads in flight
        disp_req = 1'b1; disp_addr = 23'h000044;
        step();
        disp_addr = 23'h000055;
        step();
        disp_req = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk) chk_zero("t5_rst");
        repeat (4) step();
        disp_req = 1'b1; disp_addr = 23'h000066;
        @(negedge clk) chk_val("t5_dgnt", 32'(disp_gnt), 32'd1);
        push_rd(cyc + 4, 1'b0, disp_addr);
        step();
        disp_req = 1'b0;
        @(negedge clk);
        chk_val("t5_read", 32'(read), 32'd1);
        chk_val("t5_addr", 32'(address), 32'h000066);
        repeat (6) step();

        chk_val("sb_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
